kf_multi_ch_seq: RTL

- Time-multiplexes one shared 2-state Kalman-filter core across `NCH` independent measurement channels.
- Keeps each channel's state vector and covariance, the words x1, x2, p11, p12, p21, p22, in a local state RAM.
- For every accepted measurement it reloads that channel's state plus a shared model-coefficient table into the core, then writes the updated state back.
- Sits between the sensor front-ends and the KF core, replacing a single-channel, hard-coded-init wrapper.

---
 rtl/kf_multi_ch_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/kf_multi_ch_seq.sv
// kf_multi_ch_seq: shares one 2-state Kalman core across NCH channels with per-channel state RAM
// Ports: meas_* measurement handshake, cfg_* config writes (IDLE only), core_* core load/result,
// out_* filtered x1/x2 per job, busy (FSM not IDLE), err_tmo sticky watchdog flag.
// Optional: define KF_MCH_WATCHDOG_EN to abort COLLECT after TMO idle cycles.
module kf_multi_ch_seq #(
  parameter int W         = 24,
  parameter int FRAC      = 14,
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int LOOP_ADDR = 20,
  parameter int TMO       = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           meas_valid_i,
  input  logic [CHW-1:0] meas_ch_i,
  input  logic [W-1:0]   meas_data_i,
  output logic           meas_ready_o,
  input  logic           cfg_we_i,
  input  logic [CHW-1:0] cfg_ch_i,
  input  logic [4:0]     cfg_idx_i,
  input  logic [W-1:0]   cfg_data_i,
  output logic           cfg_ready_o,
  output logic           core_start_o,
  output logic [W-1:0]   core_data_in_o,
  output logic [7:0]     core_loop_addr_o,
  input  logic           core_out_valid_i,
  input  logic [W-1:0]   core_data_out_i,
  output logic           out_valid_o,
  output logic [CHW-1:0] out_ch_o,
  output logic [W-1:0]   out_pos_o,
  output logic [W-1:0]   out_vel_o,
  output logic           busy_o,
  output logic           err_tmo_o
);
  localparam logic [W-1:0] ONE  = W'(1 << FRAC);
  localparam logic [W-1:0] X2_0 = W'((3 << FRAC) / 100);
  localparam logic [W-1:0] TENTH = W'((1 << FRAC) / 10);
  localparam logic [W-1:0] HUNDREDTH = W'((1 << FRAC) / 100);
  typedef enum logic [2:0] {IDLE, START, LOAD, MEAS, COLLECT, WB} state_t;
  state_t         state_q;
  logic [W-1:0]   st_q   [NCH][6];
  logic [W-1:0]   coef_q [14];
  logic [W-1:0]   cap_q  [6];
  logic [W-1:0]   pend_data_q [NCH];
  logic [NCH-1:0] pend_q;
  logic [CHW-1:0] ptr_q, ch_q, out_ch_q;
  logic [4:0]     idx_q;
  logic [2:0]     bcnt_q;
  logic           core_start_q, out_valid_q;
  logic [W-1:0]   core_din_q, out_pos_q, out_vel_q;
  logic           gnt_v;
  logic [CHW-1:0] gnt_ch, cand;
  logic [4:0]     nidx;
  logic [W-1:0]   ld_word;
`ifdef KF_MCH_WATCHDOG_EN
  localparam int WDW = $clog2(TMO + 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;
  assign err_tmo_o = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign err_tmo_o = 1'b0;
`endif
  assign meas_ready_o     = !pend_q[meas_ch_i];
  assign cfg_ready_o      = state_q == IDLE;
  assign busy_o           = state_q != IDLE;
  assign core_start_o     = core_start_q;
  assign core_loop_addr_o = core_start_q ? 8'(LOOP_ADDR) : 8'd0;
  assign core_data_in_o   = core_din_q;
  assign out_valid_o      = out_valid_q;
  assign out_ch_o         = out_ch_q;
  assign out_pos_o        = out_pos_q;
  assign out_vel_o        = out_vel_q;
  // Round-robin: walk downwards so the channel right after ptr_q is the last (winning) hit.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_ch = '0;
    cand   = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = CHW'((int'(ptr_q) + k) % NCH);
      if (pend_q[cand]) begin
        gnt_v  = 1'b1;
        gnt_ch = cand;
      end
    end
  end
  // Word presented in the next LOAD cycle; core_data_in is registered one cycle ahead.
  always_comb begin
    nidx    = (state_q == START) ? 5'd0 : idx_q + 5'd1;
    ld_word = (nidx < 5'd6) ? st_q[ch_q][nidx[2:0]] : coef_q[4'(nidx - 5'd6)];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      ptr_q        <= CHW'(NCH - 1);
      ch_q         <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      core_start_q <= 1'b0;
      core_din_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_pos_q    <= '0;
      out_vel_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        pend_data_q[c] <= '0;
        st_q[c][0] <= '0;
        st_q[c][1] <= X2_0;
        st_q[c][2] <= ONE;
        st_q[c][3] <= '0;
        st_q[c][4] <= '0;
        st_q[c][5] <= ONE;
      end
      for (int k = 0; k < 6; k++) cap_q[k] <= '0;
      for (int k = 0; k < 14; k++) coef_q[k] <= '0;
      coef_q[0]  <= ONE;
      coef_q[1]  <= TENTH;
      coef_q[3]  <= ONE;
      coef_q[4]  <= HUNDREDTH;
      coef_q[7]  <= HUNDREDTH;
      coef_q[8]  <= ONE;
      coef_q[10] <= TENTH;
`ifdef KF_MCH_WATCHDOG_EN
      wd_q  <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      if (meas_valid_i && meas_ready_o) begin
        pend_q[meas_ch_i]      <= 1'b1;
        pend_data_q[meas_ch_i] <= meas_data_i;
      end
      // Config lands in the grant cycle too, so the job started here loads the new value.
      if (cfg_we_i && state_q == IDLE) begin
        if (cfg_idx_i < 5'd6) st_q[cfg_ch_i][cfg_idx_i[2:0]] <= cfg_data_i;
        else if (cfg_idx_i < 5'd20) coef_q[4'(cfg_idx_i - 5'd6)] <= cfg_data_i;
      end
      case (state_q)
        IDLE: if (gnt_v) begin
          state_q      <= START;
          ch_q         <= gnt_ch;
          ptr_q        <= gnt_ch;
          core_start_q <= 1'b1;
        end
        START: begin
          core_start_q <= 1'b0;
          core_din_q   <= ld_word;
          idx_q        <= '0;
          state_q      <= LOAD;
        end
        LOAD: begin
          idx_q      <= idx_q + 5'd1;
          core_din_q <= (idx_q == 5'd19) ? pend_data_q[ch_q] : ld_word;
          if (idx_q == 5'd19) state_q <= MEAS;
        end
        MEAS: begin
          pend_q[ch_q] <= 1'b0;
          core_din_q   <= '0;
          bcnt_q       <= '0;
`ifdef KF_MCH_WATCHDOG_EN
          wd_q         <= '0;
`endif
          state_q      <= COLLECT;
        end
        COLLECT: if (core_out_valid_i) begin
          cap_q[bcnt_q] <= core_data_out_i;
          bcnt_q        <= bcnt_q + 3'd1;
`ifdef KF_MCH_WATCHDOG_EN
          wd_q          <= '0;
`endif
          if (bcnt_q == 3'd5) begin
            state_q     <= WB;
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_pos_q   <= cap_q[0];
            out_vel_q   <= cap_q[1];
          end
`ifdef KF_MCH_WATCHDOG_EN
        end else if (wd_q == WDW'(TMO - 1)) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
        end else begin
          wd_q <= wd_q + 1'b1;
`endif
        end
        WB: begin
          for (int k = 0; k < 6; k++) st_q[ch_q][k] <= cap_q[k];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
